ccd_line_reader: RTL
====================

Name: ccd_line_reader

Overview:
- Initiator-side controller for the linear CCD/CMOS line sensor and its 10-bit ADC.
- Generates exposure, laser, sensor pixel clock and ADC clock.
- Captures the returning ADC samples, compensates ADC pipeline latency, and emits an indexed pixel stream with frame framing.
- Sits between the sensor pins and the centroid/UART back end.

Parameters:
- PIXEL_COUNT, 512, pixels read per line (2..1024).
- CLK_DIV, 4, clk cycles per pixel period (even, >=2).
- ADC_LATENCY, 2, ADC pipeline delay in pixel periods (0..7).
- GAP_LEN, 8, clk cycles between exposure end and first pixel clock.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begin a frame when idle
- exp_len  in  16  exposure length in clk cycles; 0 treated as 1
- adc_data  in  10  ADC output bus
- sens_clk  out  1  sensor pixel clock
- adc_clk  out  1  ADC sample clock
- exposure  out  1  sensor exposure/integration gate
- laser  out  1  laser enable
- pix_data  out  10  captured pixel value
- pix_idx  out  10  pixel index 0..PIXEL_COUNT-1
- pix_valid  out  1  pix_data/pix_idx valid, one cycle per pixel
- frame_done  out  1  one-cycle pulse after last pixel
- busy  out  1  high in any state except IDLE
- peak_val  out  10  max pixel of last frame (feature)
- peak_idx  out  10  index of first max (feature)

Behaviour:
- Reset (async, any state): all outputs 0; FSM to IDLE; counters cleared. Reset mid-frame aborts with no frame_done.
- States: IDLE -> EXPOSE -> GAP -> READ -> DONE -> IDLE.
- IDLE:
  - start=1 latches exp_len and enters EXPOSE next cycle.
  - start in any other state is ignored.
- EXPOSE:
  - exposure=1 and laser=1 for exactly max(exp_len,1) clk cycles.
  - Then GAP, with exposure=0 and laser=0.
- GAP: GAP_LEN cycles, all clocks low, then READ.
- READ:
  - Runs PIXEL_COUNT+ADC_LATENCY pixel periods, each CLK_DIV cycles.
  - Phase counter p = 0..CLK_DIV-1.
  - sens_clk=1 for p < CLK_DIV/2.
  - adc_clk = ~sens_clk while in READ, 0 elsewhere.
  - adc_data is registered at p=CLK_DIV-1 of each period.
  - Sample taken in period n belongs to pixel n-ADC_LATENCY.
  - Samples for n < ADC_LATENCY are discarded.
  - Otherwise, one cycle after capture: pix_valid=1, pix_data=sample, pix_idx=n-ADC_LATENCY.
  - pix_valid is never high for two consecutive cycles.
- DONE:
  - frame_done=1 for one cycle.
  - Updates peak outputs.
  - Returns to IDLE; busy drops the same cycle.
- Pixel counter width: 11 bits internally (covers 1024+7); no wrap.
- Minimum frame length: max(exp_len,1)+GAP_LEN+(PIXEL_COUNT+ADC_LATENCY)*CLK_DIV+O(3) cycles.
- A start on the frame_done cycle is ignored; start is accepted from IDLE only.

Optional Feature:
- Macro: CCD_PEAK_DETECT_EN.
- Defined:
  - Running max over valid pixels; strictly-greater compare keeps the first max.
  - peak_val/peak_idx registered at DONE and held until the next DONE or reset.
  - An all-zero frame gives peak_val=0, peak_idx=0.
- Undefined: peak_val and peak_idx tied to 0; no compare logic.

Test Plan:
- Reset mid-READ (pixel 50):
  - All outputs 0 within the reset assertion.
  - No frame_done.
  - Next start produces a full frame of 512 pix_valid pulses.
- Start with exp_len=100, defaults:
  - exposure high exactly 100 cycles.
  - First sens_clk rise 8 cycles after exposure falls.
  - 514 sens_clk periods of 4 cycles.
  - 512 pix_valid pulses with idx 0..511 in order.
  - frame_done after idx 511.
- ADC model returning pixel data delayed 2 adc_clk rises (profile 500/800/500 at pixels 101/102/103, else 0):
  - pix_data=800 at pix_idx=102; 500 at 101 and 103; 0 elsewhere.
  - With CCD_PEAK_DETECT_EN: peak_val=800, peak_idx=102.
- Two frames with the profile shifted to 201..203:
  - Second frame gives peak_idx=202.
  - peak outputs change only at frame_done.
- exp_len=0:
  - exposure high exactly 1 cycle.
  - start pulses during EXPOSE/READ ignored; busy stays high.
- Equal maxima 700 at pixels 10 and 300:
  - peak_idx=10.
  - Without the macro: peak_val=0, peak_idx=0.

Source files
------------

// File: rtl/ccd_line_reader.sv
// ccd_line_reader: exposure/readout sequencer for a linear sensor and its pipelined ADC.
// Define CCD_PEAK_DETECT_EN to enable the running-peak tracker on peak_val/peak_idx.
module ccd_line_reader #(
    parameter int PIXEL_COUNT = 512,
    parameter int CLK_DIV     = 4,
    parameter int ADC_LATENCY = 2,
    parameter int GAP_LEN     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] exp_len,
    input  logic [9:0]  adc_data,
    output logic        sens_clk,
    output logic        adc_clk,
    output logic        exposure,
    output logic        laser,
    output logic [9:0]  pix_data,
    output logic [9:0]  pix_idx,
    output logic        pix_valid,
    output logic        frame_done,
    output logic        busy,
    output logic [9:0]  peak_val,
    output logic [9:0]  peak_idx
);

    localparam int          PW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(CLK_DIV / 2);
    localparam logic [10:0] PER_LAST = 11'(PIXEL_COUNT + ADC_LATENCY - 1);
    localparam logic [10:0] LAT      = 11'(ADC_LATENCY);
    localparam logic [15:0] GAP_LAST = 16'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_EXPOSE, S_GAP, S_READ, S_DONE} state_t;

    state_t       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  exp_q, exp_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [10:0]  period_q, period_d;
    logic [9:0]   pix_data_q, pix_data_d;
    logic [9:0]   pix_idx_q, pix_idx_d;
    logic         pix_valid_q, pix_valid_d;
    logic         done_q, done_d;
    logic         accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            exp_q       <= '0;
            phase_q     <= '0;
            period_q    <= '0;
            pix_data_q  <= '0;
            pix_idx_q   <= '0;
            pix_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            phase_q     <= phase_d;
            period_q    <= period_d;
            pix_data_q  <= pix_data_d;
            pix_idx_q   <= pix_idx_d;
            pix_valid_q <= pix_valid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        phase_d     = phase_q;
        period_d    = period_q;
        pix_data_d  = pix_data_q;
        pix_idx_d   = pix_idx_q;
        pix_valid_d = 1'b0;
        done_d      = 1'b0;
        accept      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // done_q is the frame_done cycle: a start there must not launch a frame
                if (start && !done_q) begin
                    accept   = 1'b1;
                    exp_d    = (exp_len == 16'd0) ? 16'd1 : exp_len;
                    cnt_d    = '0;
                    phase_d  = '0;
                    period_d = '0;
                    state_d  = S_EXPOSE;
                end
            end
            S_EXPOSE: begin
                if (cnt_q == exp_q - 16'd1) begin
                    cnt_d   = '0;
                    state_d = (GAP_LEN == 0) ? S_READ : S_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_READ: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    // sample from period n is pixel n-ADC_LATENCY; earlier periods only fill the pipe
                    if (period_q >= LAT) begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = adc_data;
                        pix_idx_d   = 10'(period_q - LAT);
                    end
                    if (period_q == PER_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        period_d = period_q + 11'd1;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sens_clk   = (state_q == S_READ) && (phase_q < PH_HALF);
    assign adc_clk    = (state_q == S_READ) && !(phase_q < PH_HALF);
    assign exposure   = (state_q == S_EXPOSE);
    assign laser      = (state_q == S_EXPOSE);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;
    assign pix_data   = pix_data_q;
    assign pix_idx    = pix_idx_q;
    assign pix_valid  = pix_valid_q;

`ifdef CCD_PEAK_DETECT_EN
    logic [9:0] run_val_q, run_idx_q, peak_val_q, peak_idx_q;
    logic [9:0] cand_val, cand_idx;

    // The last pixel is valid during DONE, so the published peak folds it in via cand_*
    always_comb begin
        cand_val = run_val_q;
        cand_idx = run_idx_q;
        if (pix_valid_q && (pix_data_q > run_val_q)) begin
            cand_val = pix_data_q;
            cand_idx = pix_idx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_val_q  <= '0;
            run_idx_q  <= '0;
            peak_val_q <= '0;
            peak_idx_q <= '0;
        end else begin
            if (accept) begin
                run_val_q <= '0;
                run_idx_q <= '0;
            end else begin
                run_val_q <= cand_val;
                run_idx_q <= cand_idx;
            end
            if (state_q == S_DONE) begin
                peak_val_q <= cand_val;
                peak_idx_q <= cand_idx;
            end
        end
    end

    assign peak_val = peak_val_q;
    assign peak_idx = peak_idx_q;
`else
    assign peak_val = '0;
    assign peak_idx = '0;
`endif

endmodule
